cache_control_nway: RTL

CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

---
 rtl/cache_control_nway.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way set-associative cache controller with per-set tree-PLRU replacement
// Optional performance counters: define CACHE_CTRL_PERF_EN to build hit/miss/write-back counters.
module cache_control_nway #(
  parameter  int WAYS  = 4,
  parameter  int SET_W = 3,
  localparam int TAG_W = 27 - SET_W,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SETS  = 2 ** SET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           address,
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS-1:0]       dirty,
  input  logic                  mem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_addr_sel,
  output logic                  cache_resp,
  output logic [WAYS-1:0]       ld_tag,
  output logic [WAYS-1:0]       ld_valid,
  output logic [WAYS-1:0]       ld_dirty,
  output logic [WAYS-1:0]       dirty_in,
  output logic [WAYS-1:0]       data_we,
  output logic                  data_src,
  output logic [WAY_W-1:0]      out_way,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITEBACK, S_FILL} state_e;

  state_e           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAYS-2:0]  plru_q [SETS];
  logic [WAYS-2:0]  plru_d [SETS];

  logic [TAG_W-1:0] addr_tag;
  logic [SET_W-1:0] set_idx;
  logic             req;
  logic             hit;
  logic             inv_found;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] miss_way;
  logic             plru_touch_en;
  logic [WAY_W-1:0] plru_touch_way;
  logic             unused_offset;

  // Walk the tree from the root; a 0 bit means the victim lies in the lower half
  function automatic logic [WAY_W-1:0] plru_pick(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] w;
    logic             b;
    int               node;
    w    = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) if (n == node) b = bits[n];
      w    = (w << 1) | WAY_W'(b);
      node = 2 * node + 1 + int'(b);
    end
    return w;
  endfunction

  // Point every node on the accessed way's path away from that way
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] w);
    logic [WAYS-2:0]  nxt;
    logic [WAY_W-1:0] sh;
    int               node;
    nxt  = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      sh = w >> (WAY_W - 1 - lvl);
      for (int n = 0; n < WAYS - 1; n++) if (n == node) nxt[n] = ~sh[0];
      node = 2 * node + 1 + int'(sh[0]);
    end
    return nxt;
  endfunction

  assign addr_tag      = address[31:5+SET_W];
  assign set_idx       = address[4+SET_W:5];
  assign req           = cpu_read | cpu_write;
  assign unused_offset = ^address[4:0];
  assign plru_way      = plru_pick(plru_q[set_idx]);
  assign miss_way      = inv_found ? inv_way : plru_way;

  // Tag compare and lowest-invalid search across the indexed set (lowest index wins)
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i*TAG_W +: TAG_W] == addr_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
  end

  // State and victim registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next state: a started write-back/fill always runs to completion
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_CHECK;
      S_CHECK: begin
        if (!req || hit) begin
          state_d = S_IDLE;
        end else begin
          victim_d = miss_way;
          state_d  = (valid[miss_way] && dirty[miss_way]) ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: if (mem_resp) state_d = S_FILL;
      S_FILL:      if (mem_resp) state_d = S_CHECK;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs and PLRU touch requests decoded from the current state
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr_sel   = 1'b0;
    cache_resp     = 1'b0;
    ld_tag         = '0;
    ld_valid       = '0;
    ld_dirty       = '0;
    dirty_in       = '0;
    data_we        = '0;
    data_src       = 1'b0;
    out_way        = '0;
    plru_touch_en  = 1'b0;
    plru_touch_way = '0;
    case (state_q)
      S_CHECK: begin
        if (req && hit) begin
          cache_resp     = 1'b1;
          out_way        = hit_way;
          plru_touch_en  = 1'b1;
          plru_touch_way = hit_way;
          if (cpu_write) begin
            data_we  = WAYS'(1) << hit_way;
            ld_dirty = WAYS'(1) << hit_way;
            dirty_in = WAYS'(1) << hit_way;
            data_src = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        out_way      = victim_q;
      end
      S_FILL: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          data_we        = WAYS'(1) << victim_q;
          ld_tag         = WAYS'(1) << victim_q;
          ld_valid       = WAYS'(1) << victim_q;
          ld_dirty       = WAYS'(1) << victim_q;
          plru_touch_en  = 1'b1;
          plru_touch_way = victim_q;
        end
      end
      default: ;
    endcase
  end

  // Only the indexed set's tree can change in a given cycle
  always_comb begin
    plru_d = plru_q;
    if (plru_touch_en) plru_d[set_idx] = plru_touch(plru_q[set_idx], plru_touch_way);
  end

  // PLRU tree storage, one tree per set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= plru_d[s];
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic        filled_q, filled_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  // Saturating counters; the re-check hit that closes a fill is not a hit
  always_comb begin
    filled_d     = (state_q == S_FILL) && mem_resp;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    if ((state_q == S_CHECK) && req && hit && !filled_q && (hit_count_q != '1))
      hit_count_d = hit_count_q + 32'd1;
    if ((state_q == S_CHECK) && req && !hit && (miss_count_q != '1))
      miss_count_d = miss_count_q + 32'd1;
    if ((state_q == S_WRITEBACK) && mem_resp && (wb_count_q != '1))
      wb_count_d = wb_count_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      filled_q     <= filled_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule
